// File: rtl/put_pkt_scheduler.sv
// Round-robin arbiter for the shared PUT-packet transmit path. Grants one worker
// processor at a time and inserts a programmable idle gap after every packet.
module put_pkt_scheduler #(
  parameter int NUM_PROCS = 8,
  parameter int GAP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PROCS-1:0] proc_req,
  input  logic [7:0]           proc_bit_mask,
  input  logic [3:0]           max_fpga_procs,
  input  logic [GAP_WIDTH-1:0] interpkt_gap_cycles,
  input  logic                 pkt_done,
  output logic [NUM_PROCS-1:0] proc_grant,
  output logic                 grant_valid,
  output logic [2:0]           grant_idx,
  output logic [1:0]           sched_state,
  output logic [31:0]          pkt_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  localparam logic [3:0] NUM_PROCS_W = 4'(NUM_PROCS);
  localparam logic [2:0] RR_RESET    = 3'(NUM_PROCS - 1);

  state_t               state_r;
  logic [2:0]           rr_ptr_r;
  logic [GAP_WIDTH-1:0] gap_cnt_r;

  logic [3:0]           limit_s;
  logic [NUM_PROCS-1:0] elig_s;
  logic [NUM_PROCS-1:0] onehot_s;
  logic                 pick_found_s;
  logic [2:0]           pick_idx_s;

  // First eligible index strictly after ptr (wrapping); smallest offset is assigned last and wins.
  function automatic logic [3:0] rr_pick(input logic [NUM_PROCS-1:0] elig, input logic [2:0] ptr);
    logic [3:0] res;
    int         j;
    res = 4'b0000;
    for (int k = NUM_PROCS; k >= 1; k--) begin
      j = (int'(ptr) + k) % NUM_PROCS;
      if (elig[j]) begin
        res = {1'b1, 3'(j)};
      end
    end
    return res;
  endfunction

  // Effective processor limit: min(max_fpga_procs, NUM_PROCS).
  always_comb begin
    limit_s = max_fpga_procs;
    if (max_fpga_procs > NUM_PROCS_W) begin
      limit_s = NUM_PROCS_W;
    end else begin
      limit_s = max_fpga_procs;
    end
  end

  // Eligibility vector from requests and configuration registers.
  always_comb begin
    elig_s = {NUM_PROCS{1'b0}};
    for (int i = 0; i < NUM_PROCS; i++) begin
      elig_s[i] = proc_req[i] & proc_bit_mask[i] & (4'(i) < limit_s);
    end
  end

  // Round-robin winner and its one-hot form.
  always_comb begin
    {pick_found_s, pick_idx_s} = rr_pick(elig_s, rr_ptr_r);
    onehot_s = {NUM_PROCS{1'b0}};
    for (int i = 0; i < NUM_PROCS; i++) begin
      onehot_s[i] = (pick_idx_s == 3'(i));
    end
  end

  assign sched_state = state_r;

  // Scheduler FSM with registered grant, gap counter and packet counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= RR_RESET;
      gap_cnt_r   <= {GAP_WIDTH{1'b0}};
      proc_grant  <= {NUM_PROCS{1'b0}};
      grant_valid <= 1'b0;
      grant_idx   <= 3'd0;
      pkt_count   <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            proc_grant  <= onehot_s;
            grant_valid <= 1'b1;
            grant_idx   <= pick_idx_s;
            rr_ptr_r    <= pick_idx_s;
            state_r     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Grant is held regardless of request/config changes until the packet completes.
          if (pkt_done) begin
            proc_grant  <= {NUM_PROCS{1'b0}};
            grant_valid <= 1'b0;
            grant_idx   <= 3'd0;
            pkt_count   <= pkt_count + 32'd1;
            if (interpkt_gap_cycles == {GAP_WIDTH{1'b0}}) begin
              state_r <= ST_IDLE;
            end else begin
              state_r   <= ST_GAP;
              gap_cnt_r <= interpkt_gap_cycles;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_r <= GAP_WIDTH'(1)) begin
            gap_cnt_r <= {GAP_WIDTH{1'b0}};
            state_r   <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          gap_cnt_r   <= {GAP_WIDTH{1'b0}};
          proc_grant  <= {NUM_PROCS{1'b0}};
          grant_valid <= 1'b0;
          grant_idx   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_put_pkt_scheduler.sv
// Self-checking bench for put_pkt_scheduler: directed scenarios plus a randomized
// run checked against a time-based round-robin reference model.
module tb_put_pkt_scheduler;

  localparam int NP = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  proc_req;
  logic [7:0]  proc_bit_mask;
  logic [3:0]  max_fpga_procs;
  logic [31:0] interpkt_gap_cycles;
  logic        pkt_done;
  logic [7:0]  proc_grant;
  logic        grant_valid;
  logic [2:0]  grant_idx;
  logic [1:0]  sched_state;
  logic [31:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner of the path, last winner, and the edge after which the gap ends.
  int          m_owner;
  int          m_last;
  logic [31:0] m_count;
  longint      m_idle_from;
  longint      cyc;
  logic [7:0]  exp_grant;
  logic [1:0]  exp_state;

  put_pkt_scheduler #(.NUM_PROCS(NP), .GAP_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .proc_req(proc_req), .proc_bit_mask(proc_bit_mask),
    .max_fpga_procs(max_fpga_procs), .interpkt_gap_cycles(interpkt_gap_cycles),
    .pkt_done(pkt_done), .proc_grant(proc_grant), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .sched_state(sched_state), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_elig();
    logic [7:0] e;
    int lim;
    lim = (int'(max_fpga_procs) < NP) ? int'(max_fpga_procs) : NP;
    for (int i = 0; i < NP; i++) e[i] = proc_req[i] & proc_bit_mask[i] & (i < lim);
    return e;
  endfunction

  task automatic model_outputs();
    exp_grant = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    exp_state = (m_owner >= 0) ? 2'b01 : ((cyc < m_idle_from) ? 2'b10 : 2'b00);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last = NP - 1;
    m_count = 32'd0;
    m_idle_from = cyc;
    model_outputs();
  endtask

  // One clock edge: update model from the inputs present at the edge, then sample 1 ns later.
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    e = model_elig();
    cyc++;
    if (m_owner >= 0) begin
      if (pkt_done) begin
        m_count++;
        m_owner = -1;
        m_idle_from = cyc + longint'(interpkt_gap_cycles);
      end
    end else if (cyc > m_idle_from && e != 8'd0) begin
      for (int k = 1; k <= NP; k++) begin
        if (m_owner < 0 && e[(m_last + k) % NP]) m_owner = (m_last + k) % NP;
      end
      m_last = m_owner;
    end
    model_outputs();
    #1;
  endtask

  task automatic tick(input logic done);
    pkt_done = done;
    step();
    pkt_done = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    release_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_checks += 5;
    if (proc_grant !== 8'h00) begin n_fail++; $display("FAIL reset_grant got=%h exp=00", proc_grant); end
    if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
    if (grant_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", grant_idx); end
    if (sched_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got=%b exp=00", sched_state); end
    if (pkt_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", pkt_count); end
    release_reset();
  endtask

  task automatic test_single();
    do_reset();
    proc_bit_mask = 8'hFF; max_fpga_procs = 4'd8; interpkt_gap_cycles = 32'd0;
    proc_req = 8'h01;
    tick(1'b0);
    n_checks += 2;
    if (proc_grant !== 8'h01) begin n_fail++; $display("FAIL single_first_grant got=%h exp=01", proc_grant); end
    if (sched_state !== 2'b01) begin n_fail++; $display("FAIL single_busy got=%b exp=01", sched_state); end
    for (int p = 1; p <= 2; p++) begin
      tick(1'b0); tick(1'b0); tick(1'b1);
      n_checks += 2;
      if (proc_grant !== 8'h00) begin n_fail++; $display("FAIL single_drop got=%h exp=00", proc_grant); end
      if (pkt_count !== 32'(p)) begin n_fail++; $display("FAIL single_count got=%0d exp=%0d", pkt_count, p); end
      tick(1'b0);
      tick(1'b0);
      n_checks++;
      if (proc_grant !== 8'h01) begin n_fail++; $display("FAIL single_regrant got=%h exp=01", proc_grant); end
    end
    proc_req = 8'h00;
    tick(1'b1);
  endtask

  task automatic test_rr_order();
    int order[6] = '{0, 1, 3, 0, 1, 3};
    do_reset();
    proc_req = 8'h0B; interpkt_gap_cycles = 32'd0;
    for (int p = 0; p < 6; p++) begin
      for (int w = 0; w < 10 && !grant_valid; w++) tick(1'b0);
      n_checks += 2;
      if (proc_grant !== (8'd1 << order[p])) begin n_fail++; $display("FAIL rr_grant[%0d] got=%h exp=%h", p, proc_grant, 8'd1 << order[p]); end
      if (grant_idx !== 3'(order[p])) begin n_fail++; $display("FAIL rr_idx[%0d] got=%0d exp=%0d", p, grant_idx, order[p]); end
      tick(1'b0); tick(1'b1);
    end
    n_checks++;
    if (pkt_count !== 32'd6) begin n_fail++; $display("FAIL rr_count got=%0d exp=6", pkt_count); end
    proc_req = 8'h00;
  endtask

  task automatic test_mask_max();
    logic [7:0] expg;
    do_reset();
    proc_req = 8'hFF; proc_bit_mask = 8'h0A; max_fpga_procs = 4'd8; interpkt_gap_cycles = 32'd0;
    for (int p = 0; p < 6; p++) begin
      if (p == 4) max_fpga_procs = 4'd2;
      expg = (p >= 4 || p % 2 == 0) ? 8'h02 : 8'h08;
      for (int w = 0; w < 10 && !grant_valid; w++) tick(1'b0);
      n_checks++;
      if (proc_grant !== expg) begin n_fail++; $display("FAIL mask_grant[%0d] got=%h exp=%h", p, proc_grant, expg); end
      tick(1'b1);
    end
    max_fpga_procs = 4'd0;
    for (int c = 0; c < 8; c++) begin
      tick(1'b0);
      n_checks++;
      if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL max0_nogrant got=%b exp=0", grant_valid); end
    end
    proc_bit_mask = 8'hFF; max_fpga_procs = 4'd8; proc_req = 8'h00;
  endtask

  task automatic test_gap();
    logic [7:0] expg;
    logic [1:0] exps;
    do_reset();
    proc_req = 8'h01; interpkt_gap_cycles = 32'd5;
    tick(1'b0); tick(1'b0);
    tick(1'b1);
    n_checks += 2;
    if (proc_grant !== 8'h00) begin n_fail++; $display("FAIL gap_drop got=%h exp=00", proc_grant); end
    if (sched_state !== 2'b10) begin n_fail++; $display("FAIL gap_enter got=%b exp=10", sched_state); end
    interpkt_gap_cycles = 32'd100;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0);
      expg = (i == 6) ? 8'h01 : 8'h00;
      exps = (i <= 4) ? 2'b10 : ((i == 5) ? 2'b00 : 2'b01);
      n_checks += 2;
      if (proc_grant !== expg) begin n_fail++; $display("FAIL gap_grant[T+%0d] got=%h exp=%h", i + 1, proc_grant, expg); end
      if (sched_state !== exps) begin n_fail++; $display("FAIL gap_state[T+%0d] got=%b exp=%b", i + 1, sched_state, exps); end
    end
    interpkt_gap_cycles = 32'd0; proc_req = 8'h00;
    tick(1'b1);
  endtask

  task automatic test_busy_hold();
    do_reset();
    proc_req = 8'h04; interpkt_gap_cycles = 32'd0;
    tick(1'b0);
    proc_req = 8'h00; proc_bit_mask = 8'h00; max_fpga_procs = 4'd1;
    for (int c = 0; c < 4; c++) begin
      tick(1'b0);
      n_checks += 2;
      if (proc_grant !== 8'h04) begin n_fail++; $display("FAIL hold_grant got=%h exp=04", proc_grant); end
      if (grant_idx !== 3'd2) begin n_fail++; $display("FAIL hold_idx got=%0d exp=2", grant_idx); end
    end
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    n_checks += 2;
    if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL idle_done_count got=%0d exp=1", pkt_count); end
    if (sched_state !== 2'b00) begin n_fail++; $display("FAIL idle_done_state got=%b exp=00", sched_state); end
    proc_bit_mask = 8'hFF; max_fpga_procs = 4'd8;
  endtask

  task automatic test_reset_mid();
    do_reset();
    proc_req = 8'hFF; interpkt_gap_cycles = 32'd0;
    tick(1'b0); tick(1'b1); tick(1'b0);
    reset = 1'b1;
    #2;
    n_checks += 3;
    if (proc_grant !== 8'h00) begin n_fail++; $display("FAIL rst_busy_grant got=%h exp=00", proc_grant); end
    if (sched_state !== 2'b00) begin n_fail++; $display("FAIL rst_busy_state got=%b exp=00", sched_state); end
    if (pkt_count !== 32'd0) begin n_fail++; $display("FAIL rst_busy_count got=%0d exp=0", pkt_count); end
    release_reset();
    tick(1'b0);
    n_checks++;
    if (proc_grant !== 8'h01) begin n_fail++; $display("FAIL rst_first_grant got=%h exp=01", proc_grant); end
    interpkt_gap_cycles = 32'hFFFF_FFFF;
    tick(1'b1);
    for (int c = 0; c < 20; c++) begin
      tick(1'b0);
      n_checks++;
      if (sched_state !== 2'b10 || grant_valid !== 1'b0) begin n_fail++; $display("FAIL maxgap_hold state=%b valid=%b exp=10/0", sched_state, grant_valid); end
    end
    reset = 1'b1;
    #2;
    n_checks += 2;
    if (sched_state !== 2'b00) begin n_fail++; $display("FAIL rst_gap_state got=%b exp=00", sched_state); end
    if (pkt_count !== 32'd0) begin n_fail++; $display("FAIL rst_gap_count got=%0d exp=0", pkt_count); end
    interpkt_gap_cycles = 32'd0;
    release_reset();
    tick(1'b0);
    n_checks++;
    if (proc_grant !== 8'h01) begin n_fail++; $display("FAIL rst_gap_regrant got=%h exp=01", proc_grant); end
    proc_req = 8'h00;
    tick(1'b1);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      proc_req = 8'($urandom);
      if ($urandom_range(0, 15) == 0) proc_bit_mask = 8'($urandom);
      if ($urandom_range(0, 15) == 0) max_fpga_procs = 4'($urandom_range(0, 15));
      interpkt_gap_cycles = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 12)) : 32'($urandom_range(0, 2));
      tick($urandom_range(0, 2) == 0);
      n_checks += 4;
      if (proc_grant !== exp_grant) begin n_fail++; $display("FAIL rand_grant c=%0d got=%h exp=%h", c, proc_grant, exp_grant); end
      if (grant_valid !== (exp_grant != 8'd0)) begin n_fail++; $display("FAIL rand_valid c=%0d got=%b", c, grant_valid); end
      if (sched_state !== exp_state) begin n_fail++; $display("FAIL rand_state c=%0d got=%b exp=%b", c, sched_state, exp_state); end
      if (pkt_count !== m_count) begin n_fail++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, pkt_count, m_count); end
      if (m_owner >= 0) begin
        n_checks++;
        if (grant_idx !== 3'(m_owner)) begin n_fail++; $display("FAIL rand_idx c=%0d got=%0d exp=%0d", c, grant_idx, m_owner); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    proc_req = 8'h00; proc_bit_mask = 8'hFF; max_fpga_procs = 4'd8;
    interpkt_gap_cycles = 32'd0; pkt_done = 1'b0;
    cyc = 0;
    model_reset();
    test_reset();
    test_single();
    test_rr_order();
    test_mask_max();
    test_gap();
    test_busy_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
